fifo_write_adapter: RTL and testbench
=====================================

FIFO_WRITE_ADAPTER -- requirements
Module: fifo_write_adapter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter SKID_DEPTH_LOG2, default 2, log2 of the skid-buffer entry count (DEPTH = 2^SKID_DEPTH_LOG2).
REQ-003 SHALL have port wrclk, input, 1, clock for all logic.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port inValid, input, 1, upstream word present.
REQ-006 SHALL have port inData, input, WIDTH, upstream word.
REQ-007 SHALL have port inReady, output, 1, registered; adapter accepts inData when high.
REQ-008 SHALL have port almostFull, input, 1, almost-full flag from the downstream write-side FIFO.
REQ-009 SHALL have port writeEnable, output, 1, registered downstream FIFO write strobe.
REQ-010 SHALL have port dataOut, output, WIDTH, registered downstream FIFO write data.
REQ-011 SHALL have port skidCount, output, SKID_DEPTH_LOG2+1, current skid occupancy.
REQ-012 SHALL have port stallCycles, output, 32, saturating count of backpressured cycles.

Function
REQ-013 SHALL accept a word in any cycle where inValid && inReady, storing it at the skid write pointer.
REQ-014 SHALL drain in any cycle where skidCount != 0 && !almostFull, reading the entry at the skid read pointer.
REQ-015 SHALL register the drain: writeEnable <= drain; dataOut <= drain ? entry : 0. dataOut SHALL be 0 whenever writeEnable is 0.
REQ-016 SHALL produce writeEnable for a word accepted in cycle N no earlier than cycle N+2. That earliest timing SHALL be met when almostFull is low and the skid buffer is empty.
REQ-017 SHALL update skidCount as skidCount + accept - drain. Simultaneous accept and drain SHALL leave it unchanged.
REQ-018 SHALL compute inReady <= (next skidCount < DEPTH). This is exact, with no extra margin required, and SHALL never admit a word into a full buffer.
REQ-019 SHALL honour a simultaneous accept and drain at skidCount == DEPTH-1 or DEPTH. inReady SHALL then follow REQ-018 from the resulting count.
REQ-020 SHALL use read and write pointers that are SKID_DEPTH_LOG2 bits wide and wrap modulo DEPTH without special-casing.
REQ-021 SHALL emit words to writeEnable/dataOut in exact acceptance order, with no loss or duplication.
REQ-022 SHALL react to almostFull combinationally in the same cycle. The downstream FIFO's almostFull margin absorbs the one write already registered.
REQ-023 SHALL increment stallCycles in each cycle where skidCount != 0 && almostFull, saturating at 32'hFFFFFFFF.
REQ-024 SHALL ignore inData in cycles without acceptance.

Reset
REQ-025 SHALL, while rst is high, set skidCount 0, both pointers 0, inReady 0, writeEnable 0, dataOut 0 and stallCycles 0.
REQ-026 SHALL discard skid contents on rst asserted mid-operation. Acceptance and drain in that cycle SHALL have no effect.
REQ-027 SHALL raise inReady to 1 on the first clock edge after rst deasserts.
REQ-028 SHALL NOT require skid storage contents to be reset.

Structure
REQ-029 SHALL place the default SKID_DEPTH_LOG2 as a shared constant in the team's common FIFO package, alongside the FIFO almost-full margins.
REQ-030 SHALL implement skid storage as one sub-module, skid_storage: a register array with one write port and one asynchronous read port.
REQ-031 SHALL keep counters, pointers, handshake and statistics logic in the top module. Clock-domain crossing is out of scope; the downstream FIFO performs it.

Verification
REQ-032 SHALL cover: rst, then inValid=1 with data 0x0001..0x0008 and almostFull=0 -> first writeEnable 2 cycles after first accept; dataOut sequence 0x0001..0x0008; skidCount never exceeds 1.
REQ-033 SHALL cover: almostFull=1, inValid=1 for 6 cycles with DEPTH=4 -> exactly 4 accepted; inReady low after the 4th accept; stallCycles increments every cycle with skidCount != 0.
REQ-034 SHALL cover: at skidCount=4, almostFull falls while inValid=1 -> one drain per cycle; inReady high the cycle after the first drain; all words in order.
REQ-035 SHALL cover: rst pulsed with skidCount=3 and writeEnable high -> next cycle writeEnable=0, dataOut=0, skidCount=0; stale words never appear.
REQ-036 SHALL cover: random inValid and almostFull for 10000 cycles against a reference queue -> no loss, duplication or reordering; dataOut=0 whenever !writeEnable.
REQ-037 SHALL cover: stallCycles forced to 0xFFFFFFFE, then 3 stall cycles -> holds 0xFFFFFFFF.

Source files
------------

// File: rtl/fifo_write_adapter_pkg.sv
// Shared constants and helpers for the FIFO write-side adapters.
package fifo_write_adapter_pkg;

  // Default skid buffer size: 2^2 = 4 entries.
  localparam int unsigned SKID_DEPTH_LOG2_DEFAULT = 2;

  // Almost-full margins of the downstream write-side FIFO. The write margin
  // covers the one write already registered when almostFull is seen.
  localparam int unsigned FIFO_ALMOST_FULL_MARGIN_WRITE = 1;
  localparam int unsigned FIFO_ALMOST_FULL_MARGIN_SAFE  = 2;

  // Saturating 32-bit increment used by the statistics counters.
  function automatic logic [31:0] satInc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_write_adapter_skid_storage.sv
// Skid buffer storage: register array, one write port, async read port.
module skid_storage #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              wrclk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [WIDTH-1:0]  rdData
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; only the pointers in the top decide validity.
  always_ff @(posedge wrclk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/fifo_write_adapter.sv
// Skid-buffered write adapter in front of a downstream write-side FIFO.
module fifo_write_adapter
  import fifo_write_adapter_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned SKID_DEPTH_LOG2 = SKID_DEPTH_LOG2_DEFAULT
) (
  input  logic                     wrclk,
  input  logic                     rst,
  input  logic                     inValid,
  input  logic [WIDTH-1:0]         inData,
  output logic                     inReady,
  input  logic                     almostFull,
  output logic                     writeEnable,
  output logic [WIDTH-1:0]         dataOut,
  output logic [SKID_DEPTH_LOG2:0] skidCount,
  output logic [31:0]              stallCycles
);

  localparam int unsigned DEPTH = 2 ** SKID_DEPTH_LOG2;
  localparam int unsigned PTR_W = SKID_DEPTH_LOG2;
  localparam int unsigned CNT_W = SKID_DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [WIDTH-1:0] entry;
  logic             accept;
  logic             drain;
  logic             stall;
  logic [CNT_W-1:0] cntNext;

  // Handshake and drain decisions; almostFull acts in the same cycle.
  always_comb begin
    accept  = inValid && inReady;
    drain   = (skidCount != '0) && !almostFull;
    stall   = (skidCount != '0) && almostFull;
    cntNext = skidCount + CNT_W'(accept) - CNT_W'(drain);
  end

  skid_storage #(
    .WIDTH  (WIDTH),
    .ADDR_W (PTR_W)
  ) u_storage (
    .wrclk  (wrclk),
    .wrEn   (accept && !rst),
    .wrAddr (wrPtr),
    .wrData (inData),
    .rdAddr (rdPtr),
    .rdData (entry)
  );

  // Pointers, occupancy, handshake, registered write port and statistics.
  always_ff @(posedge wrclk) begin
    if (rst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      skidCount   <= '0;
      inReady     <= 1'b0;
      writeEnable <= 1'b0;
      dataOut     <= '0;
      stallCycles <= '0;
    end else begin
      if (accept) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (drain) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      skidCount   <= cntNext;
      inReady     <= (cntNext < DEPTH_C);
      writeEnable <= drain;
      dataOut     <= drain ? entry : '0;
      if (stall) begin
        stallCycles <= satInc32(stallCycles);
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_adapter.sv
// Directed and random bench for fifo_write_adapter with a reference queue.
module tb_fifo_write_adapter;

  logic        wrclk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [15:0] inData;
  logic        inReady;
  logic        almostFull;
  logic        writeEnable;
  logic [15:0] dataOut;
  logic [2:0]  skidCount;
  logic [31:0] stallCycles;

  int checks = 0;
  int errors = 0;

  logic [15:0] q[$];
  int          mCnt   = 0;
  logic        mReady = 1'b0;
  logic        mWe    = 1'b0;
  logic [31:0] mStall = 32'd0;
  int          cyc    = 0;
  int          nWe    = 0;
  int          lastWeCyc = -1;

  always #5 wrclk = ~wrclk;

  fifo_write_adapter #(.WIDTH(16), .SKID_DEPTH_LOG2(2)) dut (
    .wrclk       (wrclk),
    .rst         (rst),
    .inValid     (inValid),
    .inData      (inData),
    .inReady     (inReady),
    .almostFull  (almostFull),
    .writeEnable (writeEnable),
    .dataOut     (dataOut),
    .skidCount   (skidCount),
    .stallCycles (stallCycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference, compare after the edge.
  task automatic step(input logic r, input logic v, input logic [15:0] d,
                      input logic af, output logic acc);
    logic drn;
    logic [15:0] exp;
    rst = r; inValid = v; inData = d; almostFull = af;
    acc = !r && v && mReady;
    drn = !r && (mCnt != 0) && !af;
    if (r) begin
      q.delete();
      mCnt = 0; mReady = 1'b0; mWe = 1'b0; mStall = 32'd0;
    end else begin
      if (acc) q.push_back(d);
      if ((mCnt != 0) && af && (mStall != 32'hFFFF_FFFF)) mStall = mStall + 32'd1;
      mCnt   = mCnt + int'(acc) - int'(drn);
      mReady = (mCnt < 4);
      mWe    = drn;
    end
    @(posedge wrclk); #1;
    cyc++;
    chk("writeEnable", 32'(writeEnable), 32'(mWe));
    chk("skidCount", 32'(skidCount), mCnt);
    chk("inReady", 32'(inReady), 32'(mReady));
    chk("stallCycles", stallCycles, mStall);
    if (writeEnable === 1'b1) begin
      nWe++;
      lastWeCyc = cyc;
      if (q.size() == 0) begin
        chk("unexpectedWrite", 32'(dataOut), 32'hDEAD_0000);
      end else begin
        exp = q.pop_front();
        chk("dataOrder", 32'(dataOut), 32'(exp));
      end
    end else begin
      chk("dataOutIdleZero", 32'(dataOut), 32'd0);
    end
  endtask

  initial begin
    logic acc;
    int   accCyc;
    int   maxSkid;
    int   nAcc;
    int   tries;
    rst = 1'b1; inValid = 1'b0; inData = '0; almostFull = 1'b0;

    // Reset and first-edge inReady rise
    step(1'b1, 1'b0, 16'h0, 1'b0, acc);
    step(1'b1, 1'b1, 16'hBEEF, 1'b0, acc);
    chk("resetDataOut", 32'(dataOut), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b0, acc);
    chk("readyAfterReset", 32'(inReady), 32'd1);

    // Streaming with no backpressure: latency 2, occupancy at most 1
    accCyc = -1; maxSkid = 0; nWe = 0; lastWeCyc = -1;
    for (int i = 1; i <= 8; i++) begin
      tries = 0;
      do begin
        step(1'b0, 1'b1, 16'(i), 1'b0, acc);
        if (acc && accCyc < 0) accCyc = cyc - 1;
        if (int'(skidCount) > maxSkid) maxSkid = int'(skidCount);
        if (nWe == 1 && lastWeCyc == cyc) chk("firstWriteLatency", 32'(cyc - accCyc), 32'd2);
        tries++;
      end while (!acc && tries < 20);
      chk("streamAcceptBound", 32'(acc), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'hFFFF, 1'b0, acc);
      if (int'(skidCount) > maxSkid) maxSkid = int'(skidCount);
    end
    chk("streamMaxSkid", 32'(maxSkid), 32'd1);
    chk("streamWrites", 32'(nWe), 32'd8);

    // Backpressure fill: exactly DEPTH accepted out of 6 offers
    nAcc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b1, acc);
      if (acc) nAcc++;
    end
    chk("fillAccepts", 32'(nAcc), 32'd4);
    chk("fillReadyLow", 32'(inReady), 32'd0);
    chk("fillStall", stallCycles, 32'd5);

    // Release backpressure at full: one drain per cycle, ready returns
    step(1'b0, 1'b1, 16'h0200, 1'b0, acc);
    chk("readyAfterFirstDrain", 32'(inReady), 32'd1);
    for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0, acc);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 1'b0, acc);
    chk("drainEmpty", 32'(q.size()), 32'd0);

    // Reset mid-operation with three stale words and a live write
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0300 + 16'(i), 1'b1, acc);
    step(1'b0, 1'b0, 16'h0, 1'b0, acc);
    chk("preResetCount", 32'(skidCount), 32'd3);
    chk("preResetWrite", 32'(writeEnable), 32'd1);
    step(1'b1, 1'b1, 16'h0BAD, 1'b0, acc);
    chk("postResetWe", 32'(writeEnable), 32'd0);
    chk("postResetCount", 32'(skidCount), 32'd0);
    nWe = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b0, acc);
    chk("noStaleWrites", 32'(nWe), 32'd0);

    // Random traffic against the reference queue
    for (int i = 0; i < 10000; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0), acc);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 1'b0, acc);
    chk("randomDrained", 32'(q.size()), 32'd0);

    // Stall counter saturation
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 16'h0400 + 16'(i), 1'b1, acc);
    force dut.stallCycles = 32'hFFFF_FFFE;
    #1;
    release dut.stallCycles;
    mStall = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1, acc);
    chk("stallSaturated", stallCycles, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b0, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
